// File: rtl/spi_feeder_pkg.sv
// spi_feeder_pkg: shared state type, default sizes and count-width helper for the SPI transmit feeder
package spi_feeder_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/spi_feeder_fifo.sv
// spi_feeder_fifo: synchronous FIFO with occupancy count, full/empty flags and async active-low reset
module spi_feeder_fifo
  import spi_feeder_pkg::*;
#(
  parameter int DATA_W = spi_feeder_pkg::DATA_W,
  parameter int DEPTH  = spi_feeder_pkg::DEPTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: buffers producer words and frames each as a fixed-length active-low chip-select pulse
module spi_tx_feeder
  import spi_feeder_pkg::*;
#(
  parameter int DATA_W      = spi_feeder_pkg::DATA_W,
  parameter int DEPTH       = spi_feeder_pkg::DEPTH,
  parameter int XFER_CYCLES = 18,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    s_valid,
  input  logic [DATA_W-1:0]       s_data,
  output logic                    s_ready,
  output logic [DATA_W-1:0]       data_in,
  output logic                    cs_in,
  output logic                    busy,
  output logic [cnt_w(DEPTH)-1:0] fifo_count,
  output logic [15:0]             words_sent
);
  localparam int CW = cnt_w(DEPTH);
  localparam int TW = $clog2(XFER_CYCLES > GAP_CYCLES ? XFER_CYCLES : GAP_CYCLES) + 1;
  state_t state, state_nx;
  logic [TW-1:0] tmr;
  logic [DATA_W-1:0] head;
  logic [CW-1:0] cnt_nx;
  logic push, pop, full, empty, start, tmr_done;
  assign push     = s_valid && s_ready && !full;
  assign start    = !empty && enable;
  assign tmr_done = tmr == '0;
  always_comb begin
    state_nx = state == IDLE  ? (start ? SETUP : IDLE)
             : state == SETUP ? XFER
             : state == XFER  ? (tmr_done ? GAP : XFER)
             : tmr_done       ? (start ? SETUP : IDLE) : GAP;
    pop      = state_nx == SETUP;
    cnt_nx   = fifo_count + CW'(push) - CW'(pop);
  end
  spi_feeder_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (s_data),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      tmr        <= '0;
      data_in    <= '0;
      cs_in      <= 1'b1;
      busy       <= 1'b0;
      s_ready    <= 1'b0;
      words_sent <= '0;
    end else begin
      state      <= state_nx;
      tmr        <= state == SETUP ? TW'(XFER_CYCLES - 1)
                  : (state == XFER && tmr_done) ? TW'(GAP_CYCLES - 1)
                  : tmr_done ? tmr : tmr - TW'(1);
      data_in    <= pop ? head : data_in;
      cs_in      <= state_nx != XFER;
      busy       <= state_nx != IDLE;
      s_ready    <= cnt_nx < CW'(DEPTH);
      words_sent <= (state == XFER && tmr_done) ? words_sent + 16'd1 : words_sent;
    end
endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb_spi_tx_feeder: scoreboard-based self-checking bench for spi_tx_feeder
module tb_spi_tx_feeder;
  localparam int XFER = 18;
  localparam int GAPC = 2;
  logic clk, reset_n, enable, s_valid;
  logic [7:0] s_data, data_in;
  logic s_ready, cs_in, busy;
  logic [2:0] fifo_count;
  logic [15:0] words_sent;
  int checks = 0;
  int errors = 0;
  logic [7:0] q [$];
  logic prev_cs = 1'b1;
  logic have_prev = 1'b0;
  logic gap_chk = 1'b0;
  int low_len = 0;
  int high_len = 0;

  spi_tx_feeder #(.DATA_W(8), .DEPTH(4), .XFER_CYCLES(XFER), .GAP_CYCLES(GAPC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .data_in    (data_in),
    .cs_in      (cs_in),
    .busy       (busy),
    .fifo_count (fifo_count),
    .words_sent (words_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (reset_n && s_valid && s_ready) q.push_back(s_data);

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      prev_cs = 1'b1;
      have_prev = 1'b0;
      low_len = 0;
      high_len = 0;
    end else begin
      if (prev_cs && !cs_in) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: cs_in fell with data_in=%h but no word was pushed", data_in);
        end else begin
          logic [7:0] exp;
          exp = q.pop_front();
          if (data_in !== exp) begin
            errors++;
            $display("FAIL word_order: data_in=%h required %h", data_in, exp);
          end
        end
        if (gap_chk && have_prev) begin
          checks++;
          if (high_len != GAPC + 1) begin
            errors++;
            $display("FAIL cs_gap: cs_in high %0d cycles required %0d", high_len, GAPC + 1);
          end
        end
        low_len = 0;
      end
      if (!prev_cs && cs_in) begin
        checks++;
        if (low_len != XFER) begin
          errors++;
          $display("FAIL cs_low_len: cs_in low %0d cycles required %0d", low_len, XFER);
        end
        have_prev = 1'b1;
        high_len = 0;
      end
      if (!cs_in) low_len++;
      else high_len++;
      prev_cs = cs_in;
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < max) begin
      tick;
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b fifo_count=%0d still active after %0d cycles", name, busy, fifo_count, max);
    end
  endtask

  task automatic wait_cs_low(input int max, input string name);
    int n = 0;
    while (cs_in !== 1'b0 && n < max) begin
      tick;
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s_cs_timeout: cs_in=%b required 0 within %0d cycles", name, cs_in, max);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    enable = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h77;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_in, data_in, s_ready, busy, fifo_count, words_sent} !== {1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state: cs=%b data=%h rdy=%b busy=%b cnt=%0d sent=%0d required 1 00 0 0 0 0",
               cs_in, data_in, s_ready, busy, fifo_count, words_sent);
    end
    reset_n = 1'b1;
    s_valid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_release: s_ready=%b required 0", s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL ready_after_release: s_ready=%b fifo_count=%0d required 1 and 0", s_ready, fifo_count);
    end
  endtask

  task automatic test_single;
    s_valid = 1'b1;
    s_data = 8'hA5;
    tick;
    s_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL single_count_t: fifo_count=%0d required 1", fifo_count);
    end
    tick;
    checks++;
    if (fifo_count !== 3'd0 || data_in !== 8'hA5 || cs_in !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_setup: cnt=%0d data=%h cs=%b busy=%b required 0 a5 1 1", fifo_count, data_in, cs_in, busy);
    end
    for (int k = 2; k <= 22; k++) begin
      tick;
      checks++;
      if (cs_in !== (k > XFER + 1) || busy !== (k <= 21)) begin
        errors++;
        $display("FAIL single_timing_t%0d: cs=%b busy=%b required %b %b", k, cs_in, busy, k > XFER + 1, k <= 21);
      end
    end
    checks++;
    if (words_sent !== 16'd1 || data_in !== 8'hA5) begin
      errors++;
      $display("FAIL single_done: words_sent=%0d data_in=%h required 1 a5", words_sent, data_in);
    end
  endtask

  task automatic test_burst;
    logic acc;
    logic saw_full = 1'b0;
    int n;
    have_prev = 1'b0;
    gap_chk = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i);
      n = 0;
      do begin
        acc = s_ready;
        if (fifo_count == 3'd4) begin
          saw_full = 1'b1;
          checks++;
          if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL burst_full_ready: s_ready=%b with fifo_count=4 required 0", s_ready);
          end
        end
        tick;
        n++;
      end while (!acc && n < 60);
    end
    s_valid = 1'b0;
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL burst_fill: fifo never reached count 4, required to fill");
    end
    wait_idle(400, "burst");
    checks++;
    if (words_sent !== 16'd7 || q.size() != 0) begin
      errors++;
      $display("FAIL burst_done: words_sent=%0d pending=%0d required 7 and 0", words_sent, q.size());
    end
    gap_chk = 1'b0;
  endtask

  task automatic test_enable_gating;
    int n = 0;
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = 8'(i);
      tick;
    end
    s_valid = 1'b0;
    wait_cs_low(10, "enable");
    repeat (5) tick;
    enable = 1'b0;
    while (cs_in === 1'b0 && n < 40) begin
      tick;
      n++;
    end
    for (int k = 0; k < 12; k++) begin
      tick;
      checks++;
      if (cs_in !== 1'b1) begin
        errors++;
        $display("FAIL enable_hold_%0d: cs_in=%b required 1 while disabled", k, cs_in);
      end
    end
    checks++;
    if (busy !== 1'b0 || fifo_count !== 3'd2 || words_sent !== 16'd8 || data_in !== 8'h01) begin
      errors++;
      $display("FAIL enable_parked: busy=%b cnt=%0d sent=%0d data=%h required 0 2 8 01", busy, fifo_count, words_sent, data_in);
    end
    enable = 1'b1;
    wait_idle(200, "enable");
    checks++;
    if (words_sent !== 16'd10 || q.size() != 0) begin
      errors++;
      $display("FAIL enable_resume: words_sent=%0d pending=%0d required 10 and 0", words_sent, q.size());
    end
  endtask

  task automatic test_reset_mid;
    s_valid = 1'b1;
    s_data = 8'h5A;
    tick;
    s_data = 8'h6B;
    tick;
    s_valid = 1'b0;
    wait_cs_low(10, "rstmid");
    repeat (8) tick;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cs_in !== 1'b1 || fifo_count !== 3'd0 || words_sent !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: cs=%b cnt=%0d sent=%0d busy=%b required 1 0 0 0", cs_in, fifo_count, words_sent, busy);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick;
      checks++;
      if (cs_in !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet_%0d: cs=%b busy=%b required 1 0", k, cs_in, busy);
      end
    end
    checks++;
    if (words_sent !== 16'd0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_after: words_sent=%0d fifo_count=%0d required 0 0", words_sent, fifo_count);
    end
  endtask

  task automatic test_simul_push_pop;
    enable = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h11;
    tick;
    s_valid = 1'b0;
    tick;
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_pre: fifo_count=%0d busy=%b required 1 0", fifo_count, busy);
    end
    have_prev = 1'b0;
    gap_chk = 1'b1;
    enable = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h3C;
    tick;
    s_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || busy !== 1'b1 || data_in !== 8'h11) begin
      errors++;
      $display("FAIL simul_edge: cnt=%0d busy=%b data=%h required 1 1 11", fifo_count, busy, data_in);
    end
    wait_idle(200, "simul");
    checks++;
    if (words_sent !== 16'd2 || q.size() != 0 || data_in !== 8'h3C) begin
      errors++;
      $display("FAIL simul_done: sent=%0d pending=%0d data=%h required 2 0 3c", words_sent, q.size(), data_in);
    end
    gap_chk = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_enable_gating;
    test_reset_mid;
    test_simul_push_pop;
    repeat (2) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
